// File: rtl/tone_bank_pkg.sv
// Shared types and helpers for the multi-channel test-tone generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: per-channel waveform mode encoding, mix FSM state encoding,
// and the signed full-scale limits used when saturating the channel mix.
package tone_bank_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_SQUARE  = 2'b01,
        MODE_IMPULSE = 2'b10,
        MODE_SAW     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_SAT   = 2'b10,
        ST_OUT   = 2'b11
    } mix_state_e;

    // Largest positive value of a w-bit two's complement sample.
    function automatic longint sample_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value of a w-bit two's complement sample.
    function automatic longint sample_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/tone_bank_gen_voice.sv
// Waveform generator for one tone channel, shared across all channels by the mix FSM.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent decides which channel's state is presented each cycle.
//
// Ports:
//   mode        waveform select for the channel being evaluated
//   phase       channel phase before this sample's increment
//   phase_inc   per-sample phase step
//   imp_cnt     remaining impulse-high samples for the channel
//   shift       arithmetic right shift applied to the contribution
//   contrib     signed, attenuated contribution to the mix
//   phase_next  phase to store back (held at zero while off)
//   imp_next    impulse counter to store back
module tone_channel_voice
    import tone_bank_pkg::*;
#(
    parameter int PHASE_W     = 32,
    parameter int SAMPLE_W    = 16,
    parameter int IMPULSE_LEN = 4,
    parameter int CNT_W       = 3
) (
    input  mode_e                       mode,
    input  logic [PHASE_W-1:0]          phase,
    input  logic [PHASE_W-1:0]          phase_inc,
    input  logic [CNT_W-1:0]            imp_cnt,
    input  logic [3:0]                  shift,
    output logic signed [SAMPLE_W-1:0]  contrib,
    output logic [PHASE_W-1:0]          phase_next,
    output logic [CNT_W-1:0]            imp_next
);

    localparam logic signed [SAMPLE_W-1:0] MAX_VAL = SAMPLE_W'(sample_max(SAMPLE_W));

    logic [PHASE_W:0]            sum;
    logic                        wrap;
    logic signed [SAMPLE_W-1:0]  raw;

    // The carry out of the phase add marks the end of one tone period.
    assign sum  = {1'b0, phase} + {1'b0, phase_inc};
    assign wrap = sum[PHASE_W];

    always_comb begin
        raw        = '0;
        phase_next = sum[PHASE_W-1:0];
        imp_next   = '0;
        case (mode)
            MODE_OFF: begin
                phase_next = '0;
            end
            MODE_SQUARE: begin
                raw = phase[PHASE_W-1] ? -MAX_VAL : MAX_VAL;
            end
            MODE_IMPULSE: begin
                // Output uses the counter as it stood before this sample, so a
                // wrap shows up as full scale starting on the following sample.
                raw = (imp_cnt != '0) ? MAX_VAL : '0;
                if (wrap) begin
                    imp_next = CNT_W'(IMPULSE_LEN);
                end else if (imp_cnt != '0) begin
                    imp_next = imp_cnt - 1'b1;
                end
            end
            MODE_SAW: begin
                raw = $signed(phase[PHASE_W-1 -: SAMPLE_W]);
            end
            default: begin
                raw = '0;
            end
        endcase
        contrib = raw >>> shift;
    end

endmodule

// File: rtl/tone_bank_gen.sv
// Multi-channel test-tone source: mixes NUM_CH square/impulse/saw channels into one saturated sample.
// Latency: sample_valid pulses NUM_CH+2 cycles after each sample_tick.
// Backpressure: none; the sink must accept every sample_valid pulse.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   ch_phase_inc   per-channel phase step, channel c at [c*PHASE_W +: PHASE_W]
//   ch_mode        per-channel mode, 00 off / 01 square / 10 impulse / 11 saw
//   ch_shift       per-channel attenuation shift 0..15
//   sample_tick    one-cycle pulse at the start of each sample period
//   sample_out     saturated signed mix, held between updates
//   sample_valid   one-cycle pulse when sample_out updates
//   clip           set when the last published sample was clamped
//   busy           high while the mix FSM is working on a frame
module tone_bank_gen
    import tone_bank_pkg::*;
#(
    parameter int CYCLES_PER_SAMPLE = 2272,
    parameter int NUM_CH            = 4,
    parameter int PHASE_W           = 32,
    parameter int SAMPLE_W          = 16,
    parameter int IMPULSE_LEN       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*PHASE_W-1:0]   ch_phase_inc,
    input  logic [NUM_CH*2-1:0]         ch_mode,
    input  logic [NUM_CH*4-1:0]         ch_shift,
    output logic                        sample_tick,
    output logic signed [SAMPLE_W-1:0]  sample_out,
    output logic                        sample_valid,
    output logic                        clip,
    output logic                        busy
);

    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = $clog2(IMPULSE_LEN + 1);
    localparam int SCNT_W = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sample_max(SAMPLE_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sample_min(SAMPLE_W));

    // The mix must finish before the next tick, otherwise a frame would be dropped.
    if (CYCLES_PER_SAMPLE < NUM_CH + 4) begin : g_bad_cycles_per_sample
        $error("tone_bank_gen: CYCLES_PER_SAMPLE must be >= NUM_CH+4");
    end
    if (PHASE_W < SAMPLE_W) begin : g_bad_phase_w
        $error("tone_bank_gen: PHASE_W must be >= SAMPLE_W");
    end

    // ---------------------------------------------------------------
    // Sample-rate strobe
    // ---------------------------------------------------------------
    logic [SCNT_W-1:0] samp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt    <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (samp_cnt == '0);
            if (samp_cnt == SCNT_W'(CYCLES_PER_SAMPLE - 1)) begin
                samp_cnt <= '0;
            end else begin
                samp_cnt <= samp_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Per-channel state and frame snapshot
    // ---------------------------------------------------------------
    mix_state_e                 state;
    logic [CH_W-1:0]            ch_idx;
    logic signed [ACC_W-1:0]    acc;
    logic [NUM_CH*2-1:0]        mode_q;
    logic [NUM_CH*PHASE_W-1:0]  inc_q;
    logic [NUM_CH*4-1:0]        shift_q;
    logic [PHASE_W-1:0]         phase   [NUM_CH];
    logic [CNT_W-1:0]           imp_cnt [NUM_CH];

    mode_e                      v_mode;
    logic signed [SAMPLE_W-1:0] v_contrib;
    logic [PHASE_W-1:0]         v_phase_next;
    logic [CNT_W-1:0]           v_imp_next;

    assign v_mode = mode_e'(mode_q[ch_idx*2 +: 2]);

    tone_channel_voice #(
        .PHASE_W     (PHASE_W),
        .SAMPLE_W    (SAMPLE_W),
        .IMPULSE_LEN (IMPULSE_LEN),
        .CNT_W       (CNT_W)
    ) u_voice (
        .mode       (v_mode),
        .phase      (phase[ch_idx]),
        .phase_inc  (inc_q[ch_idx*PHASE_W +: PHASE_W]),
        .imp_cnt    (imp_cnt[ch_idx]),
        .shift      (shift_q[ch_idx*4 +: 4]),
        .contrib    (v_contrib),
        .phase_next (v_phase_next),
        .imp_next   (v_imp_next)
    );

    // ---------------------------------------------------------------
    // Saturation of the accumulated mix
    // ---------------------------------------------------------------
    logic signed [SAMPLE_W-1:0] sat_val;
    logic                       sat_clip;

    always_comb begin
        sat_val  = acc[SAMPLE_W-1:0];
        sat_clip = 1'b0;
        if (acc > ACC_MAX) begin
            sat_val  = ACC_MAX[SAMPLE_W-1:0];
            sat_clip = 1'b1;
        end else if (acc < ACC_MIN) begin
            sat_val  = ACC_MIN[SAMPLE_W-1:0];
            sat_clip = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Mix FSM: IDLE -> ACCUM (one cycle per channel) -> SAT -> OUT
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ch_idx       <= '0;
            acc          <= '0;
            mode_q       <= '0;
            inc_q        <= '0;
            shift_q      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            clip         <= 1'b0;
            busy         <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                phase[c]   <= '0;
                imp_cnt[c] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        // Freeze the channel configuration for the whole frame.
                        mode_q  <= ch_mode;
                        inc_q   <= ch_phase_inc;
                        shift_q <= ch_shift;
                        acc     <= '0;
                        ch_idx  <= '0;
                        busy    <= 1'b1;
                        state   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    phase[ch_idx]   <= v_phase_next;
                    imp_cnt[ch_idx] <= v_imp_next;
                    acc <= acc + {{(ACC_W-SAMPLE_W){v_contrib[SAMPLE_W-1]}}, v_contrib};
                    if (ch_idx == CH_W'(NUM_CH - 1)) begin
                        state <= ST_SAT;
                    end else begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
                ST_SAT: begin
                    // Outputs are registered on the way into OUT so they are
                    // visible, with the valid pulse, for the OUT cycle.
                    sample_out   <= sat_val;
                    clip         <= sat_clip;
                    sample_valid <= 1'b1;
                    state        <= ST_OUT;
                end
                ST_OUT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_bank_gen.sv
// Self-checking bench for tone_bank_gen with 2 channels, 16 cycles per sample, IMPULSE_LEN=2.
// Latency: expects sample_valid NUM_CH+2 cycles after each tick.
// Backpressure: none; every valid sample is scored against a FIFO of expected values.
module tb_tone_bank_gen;

    logic               clk;
    logic               rst;
    logic [63:0]        ch_phase_inc;
    logic [3:0]         ch_mode;
    logic [7:0]         ch_shift;
    logic               sample_tick;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               clip;
    logic               busy;

    tone_bank_gen #(
        .CYCLES_PER_SAMPLE (16),
        .NUM_CH            (2),
        .PHASE_W           (32),
        .SAMPLE_W          (16),
        .IMPULSE_LEN       (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_phase_inc (ch_phase_inc),
        .ch_mode      (ch_mode),
        .ch_shift     (ch_shift),
        .sample_tick  (sample_tick),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .clip         (clip),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         smp;
        logic       clp;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  m0, m1;
        logic [31:0] i0, i1;
        logic [3:0]  s0, s1;
        int          smp;
        logic        clp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;
    int   tick_busy_viol = 0;
    int   cyc;

    // Cycle index since reset release: first post-release edge is cycle 1.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Scoreboard: every valid sample pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (sample_tick && busy) tick_busy_viol++;
            if (sample_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid at cycle %0d sample=%0d, no sample was due", cyc, sample_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (sample_out !== 16'(e.smp) || clip !== e.clp) begin
                        failures++;
                        $display("FAIL %s got sample=%0d clip=%b, want sample=%0d clip=%b",
                                 e.name, sample_out, clip, e.smp, e.clp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic set_cfg(input logic [1:0] m0, input logic [1:0] m1,
                           input logic [31:0] i0, input logic [31:0] i1,
                           input logic [3:0] s0, input logic [3:0] s1);
        ch_mode      = {m1, m0};
        ch_phase_inc = {i1, i0};
        ch_shift     = {s1, s0};
    endtask

    task automatic expect_smp(input string nm, input int smp, input logic clp);
        exp_t e;
        e.name = nm; e.smp = smp; e.clp = clp;
        sb.push_back(e);
    endtask

    task automatic wait_tick(input string nm, output int at);
        at = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sample_tick) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++; failures++;
            $display("FAIL %s_timeout no sample_tick within 40 cycles", nm);
        end
    endtask

    task automatic wait_valid(input string nm, output int at);
        at = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sample_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++; failures++;
            $display("FAIL %s_timeout no sample_valid within 40 cycles", nm);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [1:0] m0, input logic [1:0] m1,
                                input logic [31:0] i0, input logic [31:0] i1,
                                input logic [3:0] s0, input logic [3:0] s1,
                                input int smp, input logic clp);
        vec_t v;
        v.name = nm; v.m0 = m0; v.m1 = m1; v.i0 = i0; v.i1 = i1;
        v.s0 = s0; v.s1 = s1; v.smp = smp; v.clp = clp;
        return v;
    endfunction

    initial begin
        int t;
        int v;

        // One row per frame; phase state carries from row to row.
        vecs.push_back(mk("all_off",   2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 0, 1'b0));
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk("square_p0", 2'b01, 2'b00, 32'h4000_0000, 32'h0, 4'd0, 4'd0,  32767, 1'b0));
            vecs.push_back(mk("square_p1", 2'b01, 2'b00, 32'h4000_0000, 32'h0, 4'd0, 4'd0,  32767, 1'b0));
            vecs.push_back(mk("square_p2", 2'b01, 2'b00, 32'h4000_0000, 32'h0, 4'd0, 4'd0, -32767, 1'b0));
            vecs.push_back(mk("square_p3", 2'b01, 2'b00, 32'h4000_0000, 32'h0, 4'd0, 4'd0, -32767, 1'b0));
        end
        vecs.push_back(mk("off_zero_phase", 2'b00, 2'b00, 32'h4000_0000, 32'h0, 4'd0, 4'd0, 0, 1'b0));
        for (int s = 0; s < 10; s++) begin
            int want;
            want = (s == 4 || s == 5 || s == 8 || s == 9) ? 32767 : 0;
            vecs.push_back(mk($sformatf("impulse_s%0d", s), 2'b10, 2'b00, 32'h4000_0000, 32'h0,
                              4'd0, 4'd0, want, 1'b0));
        end
        vecs.push_back(mk("off_after_imp", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 0, 1'b0));
        vecs.push_back(mk("sat_pos_both",  2'b01, 2'b01, 32'h0, 32'h0, 4'd0, 4'd0, 32767, 1'b1));
        vecs.push_back(mk("sat_pos_sh1",   2'b01, 2'b01, 32'h0, 32'h0, 4'd0, 4'd1, 32767, 1'b1));
        vecs.push_back(mk("nosat_sh2",     2'b01, 2'b01, 32'h0, 32'h0, 4'd2, 4'd2, 16382, 1'b0));
        vecs.push_back(mk("sat_hi_half",   2'b01, 2'b01, 32'h8000_0000, 32'h8000_0000, 4'd0, 4'd0,  32767, 1'b1));
        vecs.push_back(mk("sat_neg",       2'b01, 2'b01, 32'h8000_0000, 32'h8000_0000, 4'd0, 4'd0, -32768, 1'b1));
        vecs.push_back(mk("saw_0",         2'b11, 2'b00, 32'h1000_0000, 32'h0, 4'd0, 4'd0, 0, 1'b0));
        vecs.push_back(mk("saw_1",         2'b11, 2'b00, 32'h1000_0000, 32'h0, 4'd0, 4'd0, 4096, 1'b0));
        vecs.push_back(mk("saw_2",         2'b11, 2'b00, 32'h1000_0000, 32'h0, 4'd0, 4'd0, 8192, 1'b0));
        vecs.push_back(mk("saw_3_sh4",     2'b11, 2'b00, 32'h1000_0000, 32'h0, 4'd4, 4'd0, 768, 1'b0));
        vecs.push_back(mk("off_after_saw", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 0, 1'b0));
        vecs.push_back(mk("saw_neg_0",     2'b11, 2'b00, 32'h8000_0000, 32'h0, 4'd0, 4'd0, 0, 1'b0));
        vecs.push_back(mk("saw_neg_min",   2'b11, 2'b00, 32'h8000_0000, 32'h0, 4'd0, 4'd0, -32768, 1'b0));
        vecs.push_back(mk("off_final",     2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 0, 1'b0));

        // Reset state
        rst = 1'b1;
        set_cfg(2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sample_out",   sample_out,   0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_clip",         clip,         0);
        chk("rst_busy",         busy,         0);
        chk("rst_sample_tick",  sample_tick,  0);
        rst = 1'b0;

        // Strobe and latency with all channels off
        for (int k = 0; k < 3; k++) begin
            expect_smp($sformatf("startup_off_%0d", k), 0, 1'b0);
            wait_tick($sformatf("startup_tick%0d", k), t);
            chk($sformatf("tick_cycle_%0d", k), t, 1 + 16 * k);
            if (k == 0) chk("busy_at_tick", busy, 0);
            wait_valid($sformatf("startup_valid%0d", k), v);
            chk($sformatf("valid_cycle_%0d", k), v, 5 + 16 * k);
            if (k == 0) begin
                chk("busy_in_out", busy, 1);
                @(negedge clk);
                chk("busy_after_out", busy, 0);
                chk("valid_one_cycle", sample_valid, 0);
            end
        end

        // Table-driven frames
        foreach (vecs[i]) begin
            set_cfg(vecs[i].m0, vecs[i].m1, vecs[i].i0, vecs[i].i1, vecs[i].s0, vecs[i].s1);
            expect_smp(vecs[i].name, vecs[i].smp, vecs[i].clp);
            wait_valid(vecs[i].name, v);
        end

        // Snapshot: config changes during ACCUM do not affect the current frame
        expect_smp("snap_current", 0, 1'b0);
        expect_smp("snap_next",    16383, 1'b0);
        expect_smp("snap_next2",   32767, 1'b0);
        wait_tick("snap_tick", t);
        @(posedge clk);
        @(posedge clk);
        #1;
        set_cfg(2'b11, 2'b01, 32'h4000_0000, 32'h0, 4'd0, 4'd1);
        for (int k = 0; k < 3; k++) wait_valid("snap", v);

        // Reset in the middle of a frame
        wait_tick("midrst_tick", t);
        @(posedge clk);
        #1;
        chk("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy",       busy,         0);
        chk("midrst_sample_out", sample_out,   0);
        chk("midrst_clip",       clip,         0);
        chk("midrst_valid",      sample_valid, 0);
        set_cfg(2'b11, 2'b00, 32'h4000_0000, 32'h0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_smp("post_rst_saw0", 0,     1'b0);
        expect_smp("post_rst_saw1", 16384, 1'b0);
        wait_tick("post_rst_tick", t);
        chk("post_rst_tick_cycle", t, 1);
        wait_valid("post_rst_valid", v);
        chk("post_rst_valid_cycle", v, 5);
        wait_valid("post_rst_valid2", v);
        chk("post_rst_valid2_cycle", v, 21);

        repeat (4) @(negedge clk);
        chk("tick_while_busy", tick_busy_viol, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
